// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stages.
// Holds the writeback control bit positions and the default field widths
// so that every stage decodes the WB field the same way.
package pipe_pkg;

    // Bit positions inside the WB control field
    localparam int REGWRITE_BIT = 0;
    localparam int MEMTOREG_BIT = 1;

    // Default field widths
    localparam int DEF_DATA_W = 8;
    localparam int DEF_REG_W  = 1;
    localparam int DEF_WB_W   = 2;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer for a generic payload.
// The main entry drives the outputs; the skid entry catches a beat that is
// accepted while main is stalled, so in_ready never depends on out_ready.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   flush                 drop both held beats (and any beat offered now)
//   in_valid/in_ready     upstream handshake; in_ready = no beat in skid
//   in_data [W]           incoming payload
//   out_valid/out_ready   downstream handshake
//   out_data [W]          payload of the main entry
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] main_data_p0;
    logic         main_vld_p0;
    logic [W-1:0] skid_data_p1;
    logic         skid_vld_p1;

    // Skid can only be full when main is full, so skid_vld alone
    // decides whether another beat fits.
    assign in_ready  = ~skid_vld_p1;
    assign out_valid = main_vld_p0;
    assign out_data  = main_data_p0;

    // ---- main / skid entry registers ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_data_p0 <= '0;
            main_vld_p0  <= 1'b0;
            skid_data_p1 <= '0;
            skid_vld_p1  <= 1'b0;
        end else if (flush) begin
            main_vld_p0 <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else begin
            if (!main_vld_p0 || out_ready) begin
                // Main is free this edge: refill from skid first to keep order;
                // while skid is full in_ready is low, so no new beat competes.
                if (skid_vld_p1) begin
                    main_data_p0 <= skid_data_p1;
                    main_vld_p0  <= 1'b1;
                    skid_vld_p1  <= 1'b0;
                end else if (in_valid) begin
                    main_data_p0 <= in_data;
                    main_vld_p0  <= 1'b1;
                end else begin
                    main_vld_p0  <= 1'b0;
                end
            end else if (in_valid && !skid_vld_p1) begin
                skid_data_p1 <= in_data;
                skid_vld_p1  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/memwb_stage.sv
// MEM/WB pipeline register with two-entry elastic buffering and
// forwarding outputs for the earlier stages.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   in_valid/in_ready            MEM-side handshake
//   flush                        discard all held beats
//   WB, Memout, ALUOut, RegRD    fields of the incoming beat
//   out_valid/out_ready          WB-side handshake
//   WBreg, Memreg, ALUreg,
//   RegRDreg                     registered output beat (WBreg zero in bubbles)
//   fwd_en, fwd_reg, fwd_data    forwarding source for hazard bypass
module memwb_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int WB_W   = DEF_WB_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [WB_W-1:0]   WB,
    input  logic [DATA_W-1:0] Memout,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [REG_W-1:0]  RegRD,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   WBreg,
    output logic [DATA_W-1:0] Memreg,
    output logic [DATA_W-1:0] ALUreg,
    output logic [REG_W-1:0]  RegRDreg,
    output logic              fwd_en,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int PW = WB_W + 2 * DATA_W + REG_W;

    logic [PW-1:0]     in_pay;
    logic [PW-1:0]     out_pay;
    logic [WB_W-1:0]   wb_held;

    assign in_pay = {WB, Memout, ALUOut, RegRD};

    skid_buffer #(
        .W(PW)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay)
    );

    assign {wb_held, Memreg, ALUreg, RegRDreg} = out_pay;

    // ---- output / forwarding ----
    // A bubble must never look like a register write, so WB is masked
    // while the data fields keep their last value.
    assign WBreg    = out_valid ? wb_held : '0;
    assign fwd_en   = out_valid & WBreg[REGWRITE_BIT];
    assign fwd_reg  = RegRDreg;
    assign fwd_data = WBreg[MEMTOREG_BIT] ? Memreg : ALUreg;

endmodule

// File: tb/tb_memwb_stage.sv
module tb_memwb_stage;

    typedef struct packed {
        logic [1:0] wb;
        logic [7:0] mem;
        logic [7:0] alu;
        logic [0:0] rd;
    } beat_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [1:0] WB;
    logic [7:0] Memout;
    logic [7:0] ALUOut;
    logic [0:0] RegRD;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] WBreg;
    logic [7:0] Memreg;
    logic [7:0] ALUreg;
    logic [0:0] RegRDreg;
    logic       fwd_en;
    logic [0:0] fwd_reg;
    logic [7:0] fwd_data;

    int    total = 0;
    int    bad   = 0;
    beat_t q[$];
    beat_t last;

    memwb_stage #(.DATA_W(8), .REG_W(1), .WB_W(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .WB       (WB),
        .Memout   (Memout),
        .ALUOut   (ALUOut),
        .RegRD    (RegRD),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .WBreg    (WBreg),
        .Memreg   (Memreg),
        .ALUreg   (ALUreg),
        .RegRDreg (RegRDreg),
        .fwd_en   (fwd_en),
        .fwd_reg  (fwd_reg),
        .fwd_data (fwd_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard front (or last held beat)
    task automatic check_outputs();
        bit v;
        v = (q.size() > 0);
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("WBreg", 32'(WBreg), v ? 32'(last.wb) : 32'd0);
        chk("Memreg", 32'(Memreg), 32'(last.mem));
        chk("ALUreg", 32'(ALUreg), 32'(last.alu));
        chk("RegRDreg", 32'(RegRDreg), 32'(last.rd));
        chk("fwd_en", 32'(fwd_en), 32'(v && last.wb[0]));
        chk("fwd_reg", 32'(fwd_reg), 32'(last.rd));
        chk("fwd_data", 32'(fwd_data), (v && last.wb[1]) ? 32'(last.mem) : 32'(last.alu));
    endtask

    // One clock: scoreboard update from pre-edge inputs, then check
    task automatic step();
        bit    acc;
        bit    cons;
        beat_t b;
        acc = in_valid && !flush && (q.size() < 2);
        cons = out_ready && !flush && (q.size() > 0);
        b.wb = WB; b.mem = Memout; b.alu = ALUOut; b.rd = RegRD;
        @(posedge clock);
        if (reset) begin
            q.delete();
            last = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        if (q.size() > 0) last = q[0];
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [1:0] wb, input logic [7:0] m,
                         input logic [7:0] a, input logic [0:0] r);
        in_valid = v; WB = wb; Memout = m; ALUOut = a; RegRD = r;
    endtask

    initial begin
        last = '0;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        step();
        reset = 1'b0;
        step();

        // single beat with ALU forwarding
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 8'h00, 8'h3C, 1'b1);
        step();
        chk("d1_out_valid", 32'(out_valid), 32'd1);
        chk("d1_fwd_en", 32'(fwd_en), 32'd1);
        chk("d1_fwd_reg", 32'(fwd_reg), 32'd1);
        chk("d1_fwd_data", 32'(fwd_data), 32'h3C);
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        step();
        chk("d1_drained", 32'(out_valid), 32'd0);

        // back-to-back A,B,C with downstream stalled
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 8'hA5, 8'h11, 1'b0);
        step();
        drive(1'b1, 2'b01, 8'hB6, 8'h22, 1'b1);
        step();
        chk("d2_in_ready_full", 32'(in_ready), 32'd0);
        drive(1'b1, 2'b10, 8'hC7, 8'h33, 1'b0);
        step();
        step();
        chk("d2_A_held", 32'(Memreg), 32'hA5);
        chk("d2_A_fwd", 32'(fwd_data), 32'hA5);
        out_ready = 1'b1;
        step();
        chk("d2_B_next", 32'(Memreg), 32'hB6);
        step();
        chk("d2_C_next", 32'(Memreg), 32'hC7);
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        step();
        chk("d2_empty", 32'(out_valid), 32'd0);
        step();

        // flush with both entries full and a beat on the input
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 8'h51, 8'h61, 1'b1);
        step();
        drive(1'b1, 2'b11, 8'h52, 8'h62, 1'b0);
        step();
        drive(1'b1, 2'b11, 8'h53, 8'h63, 1'b1);
        flush = 1'b1;
        step();
        chk("d3_out_valid", 32'(out_valid), 32'd0);
        chk("d3_WBreg", 32'(WBreg), 32'd0);
        chk("d3_in_ready", 32'(in_ready), 32'd1);
        flush = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        out_ready = 1'b1;
        step();
        step();

        // continuous stream, one beat per cycle
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'b01, 8'(i), 8'(i + 16), 1'(i));
            step();
            chk("d4_stream_valid", 32'(out_valid), 32'd1);
            chk("d4_stream_data", 32'(Memreg), 32'(i));
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        step();

        // asynchronous reset mid-cycle with skid full
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 8'h71, 8'h81, 1'b1);
        step();
        drive(1'b1, 2'b01, 8'h72, 8'h82, 1'b1);
        step();
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        last = '0;
        chk("d5_ar_out_valid", 32'(out_valid), 32'd0);
        chk("d5_ar_in_ready", 32'(in_ready), 32'd1);
        chk("d5_ar_Memreg", 32'(Memreg), 32'd0);
        chk("d5_ar_RegRDreg", 32'(RegRDreg), 32'd0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
